hub75_bcm_scanner: RTL
======================

Name: hub75_bcm_scanner

Overview:
Parametrised HUB75 LED-matrix scan driver with binary-code-modulation (BCM) colour depth.
- Reads pixels from a synchronous framebuffer, shifts one bit plane per row pass, then latches and displays it with plane-weighted on-time.
- Sits between the framebuffer RAM and the panel connector.
- Generalises the fixed 1-bit row scanner to configurable columns, scan rows and colour depth, with frame pacing and an enable.

Parameters:
- COLS, 32, pixels shifted per row pass (power of 2, ≥2)
- ROW_ADDR_W, 3, width of abc; scan rows = 2**ROW_ADDR_W
- COLOR_BITS, 4, bit planes per channel
- BASE_ON, 32, display cycles for plane 0; plane p displays BASE_ON<<p
- BLANK_CYC, 2, extra blanking cycles before latch (0 allowed)

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous, active-high
- enable, in, 1, start/continue frame scanning
- rd_addr, out, ROW_ADDR_W+$clog2(COLS), {row, col} framebuffer address
- rd_data, in, 6*COLOR_BITS, {r1,g1,b1,r2,g2,b2}, each COLOR_BITS wide, MSB first; valid 1 cycle after rd_addr
- r1,g1,b1,r2,g2,b2, out, 1 each, panel colour data
- abc, out, ROW_ADDR_W, panel row select
- oclk, out, 1, panel shift clock
- lat, out, 1, panel latch
- oe_n, out, 1, panel output enable, active-low
- frame_done, out, 1, one-cycle pulse at end of frame

Behaviour:
- Clock and reset: clk is the clock. reset is synchronous, active-high.
- Reset values: state IDLE, oe_n=1, lat=0, oclk=0, all colour outputs 0, abc=0, rd_addr=0, frame_done=0, row=0, plane=0.
- Reset mid-operation: all outputs return to reset values on the next edge. No partial latch.
- State sequence: IDLE → SHIFT → BLANK → LATCH → DISPLAY → (next) SHIFT or IDLE.
- IDLE: oe_n=1. Enters SHIFT with row=0, plane=0 when enable=1.
- SHIFT: lasts exactly 2*COLS+2 cycles, indexed k=0..2*COLS+1.
  - Cycle 2c (c<COLS): rd_addr={row,c}.
  - Edge starting cycle 2c+2: colour outputs load bit[plane] of the matching rd_data fields.
  - oclk=1 only during cycle 2c+3 for c=0..COLS-1; oclk=0 otherwise.
  - oe_n=1 and lat=0 throughout.
- BLANK: 1+BLANK_CYC cycles, oe_n=1, oclk=0. abc takes the current row on the first BLANK cycle.
- LATCH: one cycle, lat=1, oe_n=1.
- DISPLAY: oe_n=0 for exactly BASE_ON<<plane cycles. Counter width is $clog2(BASE_ON<<(COLOR_BITS-1))+1.
- After DISPLAY:
  - plane<COLOR_BITS-1: plane++, return to SHIFT on the same row.
  - Otherwise plane=0 and row++, wrapping from 2**ROW_ADDR_W-1 to 0.
- End of frame (last row, last plane): frame_done=1 for one cycle, coincident with the first cycle after DISPLAY. Next state is SHIFT if enable=1, else IDLE.
- enable is sampled only in IDLE and at end of frame. Dropping enable mid-frame completes the frame.
- Colour outputs hold their last value outside SHIFT.
- rd_addr holds its last value outside SHIFT.

Decomposition:
- Package hub75_pkg:
  - scan_state_t enum {IDLE, SHIFT, BLANK, LATCH, DISPLAY}
  - rd_data field-offset function/constants (R1..B2 base indices given COLOR_BITS)
- Sub-module hub75_bcm_timer: loadable down-counter for DISPLAY length. Inputs: load, plane. Output: done.

Test Plan:
1. Reset values: reset=1 for 3 cycles with enable=1 → oe_n=1, lat=0, oclk=0, abc=0, colour outputs 0, frame_done=0.
2. Shift timing: COLS=4, rd_data model returns col-dependent pattern → exactly 4 oclk pulses per SHIFT, at SHIFT cycles 3,5,7,9. Colour lines stable across each oclk high and equal bit[plane] of the addressed word.
3. BCM weighting: BASE_ON=2, COLOR_BITS=4, BLANK_CYC=2 → per row, oe_n low for 2,4,8,16 cycles. Each DISPLAY is preceded by one lat pulse with oe_n=1. Blanking gap before LATCH is 3 cycles.
4. Row wrap and frame_done: ROW_ADDR_W=3 → abc steps 0..7 then 0. frame_done is a single pulse after row 7 plane 3 DISPLAY; pulse count equals frames scanned.
5. Enable drop mid-frame: deassert enable during row 2 → scanning continues through row 7. frame_done fires, then IDLE with oe_n=1. Reassert → restarts at abc=0, plane 0.
6. Reset mid-DISPLAY: assert reset while oe_n=0 → next cycle oe_n=1 and state IDLE. After release with enable=1, first SHIFT uses row 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types and rd_data field layout for the HUB75 BCM scan driver.
// rd_data packs {r1,g1,b1,r2,g2,b2}, each COLOR_BITS wide, r1 in the top bits.
package hub75_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } scan_state_t;

    localparam int F_R1 = 0;
    localparam int F_G1 = 1;
    localparam int F_B1 = 2;
    localparam int F_R2 = 3;
    localparam int F_G2 = 4;
    localparam int F_B2 = 5;
    localparam int NUM_FIELDS = 6;

    function automatic int field_lsb(input int field, input int color_bits);
        return (NUM_FIELDS - 1 - field) * color_bits;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter timing the DISPLAY on-time: BASE_ON << plane cycles.
// done is high while the count sits at zero.
module hub75_bcm_timer #(
    parameter int BASE_ON    = 32,
    parameter int COLOR_BITS = 4,
    parameter int PW         = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [PW-1:0] plane,
    output logic          done
);

    localparam int TW = $clog2(BASE_ON << (COLOR_BITS - 1)) + 1;

    logic [TW-1:0] cnt;

    // Loaded one short so the count reaches zero on the last on-time cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (TW'(BASE_ON) << plane) - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 scan driver: shifts one bit plane of a row from the framebuffer,
// latches it and shows it for a plane-weighted time (binary code modulation).
module hub75_bcm_scanner
    import hub75_pkg::*;
#(
    parameter int COLS       = 32,
    parameter int ROW_ADDR_W = 3,
    parameter int COLOR_BITS = 4,
    parameter int BASE_ON    = 32,
    parameter int BLANK_CYC  = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    output logic [ROW_ADDR_W+$clog2(COLS)-1:0]    rd_addr,
    input  logic [6*COLOR_BITS-1:0]               rd_data,
    output logic                                  r1,
    output logic                                  g1,
    output logic                                  b1,
    output logic                                  r2,
    output logic                                  g2,
    output logic                                  b2,
    output logic [ROW_ADDR_W-1:0]                 abc,
    output logic                                  oclk,
    output logic                                  lat,
    output logic                                  oe_n,
    output logic                                  frame_done
);

    localparam int CCW       = $clog2(COLS);
    localparam int PW        = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int SHIFT_LEN = 2 * COLS + 2;
    localparam int CW        = $clog2(SHIFT_LEN + BLANK_CYC + 1);

    scan_state_t state, state_next;

    logic [CW-1:0]         cyc;
    logic [CW-1:0]         cyc_inc;
    logic [ROW_ADDR_W-1:0] row;
    logic [ROW_ADDR_W-1:0] row_inc;
    logic [PW-1:0]         plane;
    logic                  plane_last;
    logic                  frame_last;
    logic                  frame_end;
    logic                  done;
    logic [5:0]            plane_bits;

    assign cyc_inc    = cyc + 1'b1;
    assign row_inc    = row + 1'b1;
    assign plane_last = (plane == PW'(COLOR_BITS - 1));
    assign frame_last = plane_last && (row == '1);
    assign frame_end  = (state == DISPLAY) && done && frame_last;

    // Current plane's bit of each colour field, ordered {r1,g1,b1,r2,g2,b2}.
    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
        logic [COLOR_BITS-1:0] fld;
        assign fld = rd_data[field_lsb(f, COLOR_BITS) +: COLOR_BITS];
        assign plane_bits[NUM_FIELDS-1-f] = fld[plane];
    end

    hub75_bcm_timer #(
        .BASE_ON    (BASE_ON),
        .COLOR_BITS (COLOR_BITS),
        .PW         (PW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (state == LATCH),
        .plane (plane),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = SHIFT;
            SHIFT:   if (cyc == CW'(SHIFT_LEN - 1)) state_next = BLANK;
            BLANK:   if (cyc == CW'(BLANK_CYC)) state_next = LATCH;
            LATCH:   state_next = DISPLAY;
            DISPLAY: if (done) state_next = (frame_last && !enable) ? IDLE : SHIFT;
            default: state_next = IDLE;
        endcase
    end

    assign oclk = (state == SHIFT) && cyc[0] && (cyc >= CW'(3));
    assign lat  = (state == LATCH);
    assign oe_n = (state != DISPLAY);

    // Odd SHIFT cycles fetch the next column and capture the previous read.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc        <= '0;
            row        <= '0;
            plane      <= '0;
            rd_addr    <= '0;
            abc        <= '0;
            frame_done <= 1'b0;
            {r1, g1, b1, r2, g2, b2} <= '0;
        end else begin
            frame_done <= frame_end;
            cyc        <= (state_next != state) ? '0 : cyc_inc;
            case (state)
                IDLE: begin
                    if (enable) begin
                        row     <= '0;
                        plane   <= '0;
                        rd_addr <= '0;
                    end
                end
                SHIFT: begin
                    if (cyc[0] && (cyc < CW'(2 * COLS - 1)))
                        rd_addr <= {row, cyc_inc[CCW:1]};
                    if (cyc[0] && (cyc < CW'(2 * COLS)))
                        {r1, g1, b1, r2, g2, b2} <= plane_bits;
                    if (state_next == BLANK)
                        abc <= row;
                end
                DISPLAY: begin
                    if (done) begin
                        if (plane_last) begin
                            plane <= '0;
                            row   <= row_inc;
                        end else begin
                            plane <= plane + 1'b1;
                        end
                        if (state_next == SHIFT)
                            rd_addr <= {(plane_last ? row_inc : row), {CCW{1'b0}}};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
